// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback for
// lw, sw, R-type, I-type ALU, jal and beq; unsupported opcodes trap for one cycle.
module main_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t state, state_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset clears state without waiting for clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_next;
  end

  // NOTE: every output and state_next gets a default before the case so no
  // path leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_next = FETCH;
    PCUpdate   = 1'b0;
    Branch     = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    IllegalOp  = 1'b0;

    unique case (state)
      FETCH: begin
        IRWrite    = 1'b1;
        PCUpdate   = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTER;
          OP_ITYPE:     state_next = EXECUTEI;
          OP_JAL:       state_next = JAL;
          OP_BEQ:       state_next = BEQ;
          default:      state_next = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW:   state_next = MEMREAD;
          OP_SW:   state_next = MEMWRITE;
          default: state_next = TRAP;
        endcase
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        state_next = FETCH;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCUpdate   = 1'b1;
        state_next = ALUWB;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        Branch     = 1'b1;
        state_next = FETCH;
      end
      TRAP: begin
        IllegalOp  = 1'b1;
        state_next = FETCH;
      end
      // Unused codes 12-15 (e.g. after an upset) drive all outputs low and recover.
      default: state_next = FETCH;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_main_fsm.sv
// Randomized self-checking bench for main_fsm: an instruction-level model predicts
// the state-code sequence and per-state control word, including mid-instruction reset.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic       PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, IllegalOp;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state_o;

  main_fsm dut (
    .clk(clk), .reset_n(reset_n), .op(op),
    .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .IllegalOp(IllegalOp), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc, br, rw, mw, ir, adr;
    logic [1:0] rs, sa, sb, aop;
    logic       ill;
  } outs_t;

  typedef int seq_t[$];

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

  outs_t observed;
  assign observed = '{pc: PCUpdate, br: Branch, rw: RegWrite, mw: MemWrite, ir: IRWrite,
                      adr: AdrSrc, rs: ResultSrc, sa: ALUSrcA, sb: ALUSrcB, aop: ALUOp,
                      ill: IllegalOp};

  int n_checks = 0;
  int n_passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Control word each state must present, written straight from the state table.
  function automatic outs_t expected_outs(input int s);
    outs_t o = '0;
    case (s)
      0:  begin o.ir = 1; o.pc = 1; o.sb = 2'b10; o.rs = 2'b10; end
      1:  begin o.sa = 2'b01; o.sb = 2'b01; end
      2:  begin o.sa = 2'b10; o.sb = 2'b01; end
      3:  o.adr = 1;
      4:  begin o.rs = 2'b01; o.rw = 1; end
      5:  begin o.adr = 1; o.mw = 1; end
      6:  begin o.sa = 2'b10; o.aop = 2'b10; end
      7:  begin o.sa = 2'b10; o.sb = 2'b01; o.aop = 2'b10; end
      8:  o.rw = 1;
      9:  begin o.sa = 2'b01; o.sb = 2'b10; o.pc = 1; end
      10: begin o.sa = 2'b10; o.aop = 2'b01; o.br = 1; end
      11: o.ill = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  // States visited by one instruction, from FETCH up to (not including) the next FETCH.
  function automatic seq_t expected_seq(input logic [6:0] op_dec, input logic [6:0] op_mem);
    seq_t q;
    case (op_dec)
      LW, SW: begin
        if (op_mem == LW)      q = '{0, 1, 2, 3, 4};
        else if (op_mem == SW) q = '{0, 1, 2, 5};
        else                   q = '{0, 1, 2, 11};
      end
      RT:      q = '{0, 1, 6, 8};
      IT:      q = '{0, 1, 7, 8};
      JL:      q = '{0, 1, 9, 8};
      BQ:      q = '{0, 1, 10};
      default: q = '{0, 1, 11};
    endcase
    return q;
  endfunction

  // Entered and left at a falling edge with the DUT in FETCH; op is scrambled
  // in every state that must ignore it.
  task automatic run_instr(input logic [6:0] op_dec, input logic [6:0] op_mem);
    seq_t q = expected_seq(op_dec, op_mem);
    foreach (q[i]) begin
      check($sformatf("state[%0d] op=%b", i, op_dec), 32'(state_o), 32'(q[i]));
      check($sformatf("outs s=%0d", q[i]), 32'(observed), 32'(expected_outs(q[i])));
      if (q[i] == 1)      op = op_dec;
      else if (q[i] == 2) op = op_mem;
      else                op = 7'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  function automatic logic [6:0] random_op();
    logic [6:0] legal[6] = '{LW, SW, RT, IT, JL, BQ};
    if ($urandom_range(0, 5) == 0) return 7'($urandom);
    return legal[$urandom_range(0, 5)];
  endfunction

  initial begin
    logic [6:0] od, om;
    bit reached;
    reset_n = 1'b0;
    op = 7'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check("reset state", 32'(state_o), 32'd0);
    check("reset outs", 32'(observed), 32'(expected_outs(0)));
    @(negedge clk);
    reset_n = 1'b1;

    // Directed sequences, then a random instruction stream.
    run_instr(LW, LW);
    run_instr(SW, SW);
    run_instr(RT, RT);
    run_instr(IT, IT);
    run_instr(BQ, BQ);
    run_instr(JL, JL);
    run_instr(7'b1111111, 7'b1111111);
    run_instr(LW, 7'b1010101);
    for (int k = 0; k < 80; k++) begin
      od = random_op();
      om = ($urandom_range(0, 7) == 0) ? 7'($urandom) : od;
      run_instr(od, om);
    end
    check("stream end in FETCH", 32'(state_o), 32'd0);

    // Reset pulsed while a store is writing memory.
    reached = 0;
    for (int c = 0; c < 8 && !reached; c++) begin
      op = SW;
      if (state_o == 4'd5) reached = 1;
      else begin @(posedge clk); @(negedge clk); end
    end
    check("reach MEMWRITE", 32'(reached), 32'd1);
    check("MemWrite before reset", 32'(MemWrite), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset state", 32'(state_o), 32'd0);
    check("async reset MemWrite", 32'(MemWrite), 32'd0);
    check("async reset outs", 32'(observed), 32'(expected_outs(0)));
    @(posedge clk);
    #1;
    check("held reset state", 32'(state_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check("release state", 32'(state_o), 32'd0);
    @(posedge clk);
    #1;
    check("first edge after release", 32'(state_o), 32'd1);
    @(negedge clk);
    run_instr_from_decode();

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

  // Finish a beq that began before the test above, returning to FETCH.
  task automatic run_instr_from_decode();
    op = BQ;
    @(posedge clk);
    @(negedge clk);
    check("beq after reset", 32'(state_o), 32'd10);
    op = 7'($urandom);
    @(posedge clk);
    @(negedge clk);
    check("back to FETCH", 32'(state_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset; one clock domain, no other reset.
REQ-003 SHALL have port: op  input  7  opcode field of the instruction register, stable from DECODE onward.
REQ-004 SHALL have outputs (all 1 bit):
- PCUpdate: PC write enable, unconditional.
- Branch: conditional PC write request.
- RegWrite: register-file write enable.
- MemWrite: data memory write enable.
- IRWrite: instruction register write enable.
- AdrSrc: memory address select, 0=PC, 1=Result.
REQ-005 SHALL have 2-bit outputs:
- ResultSrc: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA: 00=PC, 01=OldPC, 10=RD1.
- ALUSrcB: 00=RD2, 01=ImmExt, 10=constant 4.
- ALUOp: 00=add, 01=subtract, 10=decode funct fields; this port feeds the ALU decoder's ALUOp input.
REQ-006 SHALL have outputs IllegalOp (1 bit, one-cycle unsupported-opcode flag) and state_o (4 bits, current state code, debug/verification).

Function
REQ-007 SHALL be a Moore FSM: every output a pure function of the registered state, no combinational path from op to any output.
REQ-008 SHALL use these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, JAL=9, BEQ=10, TRAP=11; codes 12-15 unused.
REQ-009 SHALL drive every output not listed for a state to 0, never X.
REQ-010 Per-state outputs:
- FETCH: IRWrite=1, PCUpdate=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- TRAP: IllegalOp=1 only.
REQ-011 Transitions from FETCH and DECODE: FETCH->DECODE always; DECODE selects by op:
- 0000011 (lw) or 0100011 (sw) -> MEMADR.
- 0110011 -> EXECUTER.
- 0010011 -> EXECUTEI.
- 1101111 -> JAL.
- 1100011 -> BEQ.
- any other value -> TRAP.
REQ-012 Remaining transitions:
- MEMADR: 0000011->MEMREAD, 0100011->MEMWRITE, other->TRAP.
- MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH.
- EXECUTER->ALUWB; EXECUTEI->ALUWB; JAL->ALUWB; ALUWB->FETCH.
- BEQ->FETCH; TRAP->FETCH.
REQ-013 Cycle counts per instruction, FETCH inclusive: lw 5, sw 4, R-type 4, I-type ALU 4, jal 4, beq 3, illegal 3.
REQ-014 SHALL return to FETCH on the next clock if the state register ever holds an unused code (12-15).
REQ-015 op changes outside DECODE/MEMADR SHALL not affect state.

Reset
REQ-016 reset_n low SHALL force state to FETCH immediately, without waiting for a clock edge; outputs then equal FETCH values (IRWrite=1, PCUpdate=1, ALUSrcB=10, ResultSrc=10, others 0, state_o=0).
REQ-017 Reset asserted mid-instruction (e.g. in MEMWRITE) SHALL drop MemWrite/RegWrite asynchronously; first state after release is FETCH, first post-release edge moves to DECODE.

Verification
REQ-018 Reset release, op=0000011: state_o sequence 0,1,2,3,4,0; RegWrite=1 only in cycle 5, ResultSrc=01 there.
REQ-019 op=0100011: sequence 0,1,2,5,0; MemWrite=1 exactly one cycle with AdrSrc=1; RegWrite never 1.
REQ-020 op=0110011 then 0010011 back-to-back: 0,1,6,8,0,1,7,8,0; ALUOp=10 in states 6 and 7; ALUSrcB 00 vs 01.
REQ-021 op=1100011: 0,1,10,0 with Branch=1, ALUOp=01 in state 10; op=1101111: 0,1,9,8,0 with PCUpdate=1 in states 0 and 9.
REQ-022 op=1111111 in DECODE: 0,1,11,0; IllegalOp=1 exactly one cycle; all write enables 0 in TRAP.
REQ-023 reset_n pulsed low mid-cycle while state=5: MemWrite falls before the next clock edge, state_o=0, resumes 0->1 after release.
